// File: rtl/cache_wb_param.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_param
// Brief    : Direct-mapped write-back / write-allocate cache, one word per
//            CPU access. Optional hit/miss counters with CACHE_WB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_wb_param #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 1,
    parameter int OFFSET_W = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [31:0]                  cpu_wdata,
    output logic [31:0]                  cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_hit,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [32*(2**OFFSET_W)-1:0]  mem_wdata,
    input  logic [32*(2**OFFSET_W)-1:0]  mem_rdata,
    input  logic                         mem_ready
`ifdef CACHE_WB_STATS_EN
    ,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int SETS  = 2**INDEX_W;
    localparam int BLK_W = 32 * (2**OFFSET_W);
    localparam int LOW_W = OFFSET_W + 2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_nextState;
    logic [ADDR_W-1:2]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic                r_missed;
    logic [SETS-1:0]     r_valid;
    logic [SETS-1:0]     r_dirty;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [BLK_W-1:0]    r_data [SETS];

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [OFFSET_W+4:0] w_bitOff;
    logic                w_hit;
    logic                w_unusedByteBits;

    // Byte-lane bits never matter: every access is a whole word.
    assign w_unusedByteBits = ^cpu_addr[1:0];

    assign w_index  = r_addr[LOW_W +: INDEX_W];
    assign w_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_bitOff = {r_addr[2 +: OFFSET_W], 5'b0};
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);

    always_comb begin
        w_nextState = r_state;
        cpu_ready   = 1'b0;
        cpu_hit     = 1'b0;
        cpu_rdata   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req) w_nextState = S_COMPARE;
            end
            S_COMPARE: begin
                if (w_hit) begin
                    cpu_ready   = 1'b1;
                    cpu_hit     = !r_missed;
                    cpu_rdata   = r_data[w_index][w_bitOff +: 32];
                    w_nextState = S_IDLE;
                end else if (r_valid[w_index] && r_dirty[w_index]) begin
                    w_nextState = S_WRITEBACK;
                end else begin
                    w_nextState = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_tag[w_index], w_index, {LOW_W{1'b0}}};
                mem_wdata = r_data[w_index];
                if (mem_ready) w_nextState = S_ALLOCATE;
            end
            default: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_index, {LOW_W{1'b0}}};
                if (mem_ready) w_nextState = S_COMPARE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_valid  <= '0;
            r_dirty  <= '0;
            r_missed <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr   <= cpu_addr[ADDR_W-1:2];
                        r_we     <= cpu_we;
                        r_wdata  <= cpu_wdata;
                        r_missed <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (w_hit && r_we) r_dirty[w_index] <= 1'b1;
                    // Remembers the miss so the post-fill hit still reports cpu_hit=0.
                    if (!w_hit) r_missed <= 1'b1;
                end
                S_WRITEBACK: begin
                    if (mem_ready) r_dirty[w_index] <= 1'b0;
                end
                default: begin
                    if (mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Line storage needs no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_COMPARE && w_hit && r_we) begin
                r_data[w_index][w_bitOff +: 32] <= r_wdata;
            end else if (r_state == S_ALLOCATE && mem_ready) begin
                r_data[w_index] <= mem_rdata;
                r_tag[w_index]  <= w_tag;
            end
        end
    end

`ifdef CACHE_WB_STATS_EN
    logic [15:0] r_hitCount;
    logic [15:0] r_missCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else if (cpu_ready) begin
            if (cpu_hit && r_hitCount != 16'hFFFF)   r_hitCount  <= r_hitCount + 16'd1;
            if (!cpu_hit && r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
        end
    end

    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_wb_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_wb_param
// Brief    : Self-checking bench for cache_wb_param against a word-level
//            memory/cache reference model. Honours CACHE_WB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_wb_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_hit;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef CACHE_WB_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    always #5 clk = ~clk;

    cache_wb_param dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef CACHE_WB_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // archMem is what the CPU should observe; bMem is the backing store.
    logic [31:0] archMem [256];
    logic [31:0] bMem    [256];
    logic        mValid  [2];
    logic        mDirty  [2];
    logic [4:0]  mTag    [2];
    logic [31:0] mBlk    [2][4];
    int          mHits;
    int          mMisses;

    task automatic clearModel();
        for (int s = 0; s < 2; s++) begin
            mValid[s] = 1'b0;
            mDirty[s] = 1'b0;
        end
        mHits   = 0;
        mMisses = 0;
    endtask

    task automatic access(input logic we, input logic [9:0] addr,
                          input logic [31:0] wd, input int lat);
        logic         idx, expHit, done, active;
        logic [4:0]   tag;
        logic [1:0]   wi;
        logic [5:0]   blk;
        logic [31:0]  expRd;
        logic         expWe   [2];
        logic [9:0]   expAddr [2];
        logic [127:0] expData [2];
        int nExp, ph, cnt, cyc, expLat;
        idx = addr[4]; tag = addr[9:5]; wi = addr[3:2]; blk = addr[9:4];
        expHit = mValid[idx] && (mTag[idx] == tag);
        expRd  = archMem[addr[9:2]];
        nExp = 0;
        if (!expHit) begin
            if (mValid[idx] && mDirty[idx]) begin
                expWe[0]   = 1'b1;
                expAddr[0] = {mTag[idx], idx, 4'b0};
                expData[0] = {mBlk[idx][3], mBlk[idx][2], mBlk[idx][1], mBlk[idx][0]};
                nExp = 1;
            end
            expWe[nExp]   = 1'b0;
            expAddr[nExp] = {blk, 4'b0};
            expData[nExp] = '0;
            nExp++;
        end
        expLat = 1 + nExp * (lat + 1) + ((nExp > 0) ? 1 : 0);

        @(posedge clk); #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got %b expected 0", cpu_ready);
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk); #1;
        cyc = 1; done = 1'b0; active = 1'b0; cnt = 0; ph = 0;
        while (!done && cyc <= 60) begin
            if (mem_ready) begin
                active    = 1'b0;
                mem_ready = 1'b0;
            end
            if (mem_req && !active) begin
                active = 1'b1;
                cnt    = 0;
                checks++;
                if (ph >= nExp) begin
                    failures++;
                    $display("FAIL extra_mem_phase addr=%h: got we=%b addr=%h expected no request",
                             addr, mem_we, mem_addr);
                end else if (mem_we !== expWe[ph] || mem_addr !== expAddr[ph] ||
                             (expWe[ph] && mem_wdata !== expData[ph])) begin
                    failures++;
                    $display("FAIL mem_phase%0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                             ph, mem_we, mem_addr, mem_wdata, expWe[ph], expAddr[ph], expData[ph]);
                end
                ph++;
            end
            if (mem_req) begin
                cnt++;
                if (cnt > lat) begin
                    mem_ready = 1'b1;
                    for (int w = 0; w < 4; w++) begin
                        if (mem_we) bMem[{mem_addr[9:4], 2'(w)}] = mem_wdata[w*32 +: 32];
                        else        mem_rdata[w*32 +: 32] = bMem[{mem_addr[9:4], 2'(w)}];
                    end
                end
            end
            if (cpu_ready) begin
                done    = 1'b1;
                cpu_req = 1'b0;
                checks++;
                if (cpu_hit !== expHit || cyc != expLat || ph != nExp) begin
                    failures++;
                    $display("FAIL access_ctrl addr=%h: got hit=%b lat=%0d phases=%0d expected hit=%b lat=%0d phases=%0d",
                             addr, cpu_hit, cyc, ph, expHit, expLat, nExp);
                end
                if (!we) begin
                    checks++;
                    if (cpu_rdata !== expRd) begin
                        failures++;
                        $display("FAIL read_data addr=%h: got %h expected %h", addr, cpu_rdata, expRd);
                    end
                end
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_timeout addr=%h: got no cpu_ready expected one within 60 cycles", addr);
            cpu_req   = 1'b0;
            mem_ready = 1'b0;
        end
        if (!expHit) begin
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mTag[idx]   = tag;
            for (int w = 0; w < 4; w++) mBlk[idx][w] = archMem[{blk, 2'(w)}];
            mMisses++;
        end else begin
            mHits++;
        end
        if (we) begin
            archMem[addr[9:2]] = wd;
            mBlk[idx][wi]      = wd;
            mDirty[idx]        = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_ready !== 1'b0 || cpu_hit !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got ready=%b hit=%b mreq=%b mwe=%b expected all 0",
                     cpu_ready, cpu_hit, mem_req, mem_we);
        end
        checks++;
        if (cpu_rdata !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 128'h0) begin
            failures++;
            $display("FAIL reset_data: got rdata=%h maddr=%h mwdata=%h expected 0",
                     cpu_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        clearModel();
    endtask

    task automatic test_directed();
        access(1'b0, 10'h000, 32'h0, 3);
        access(1'b0, 10'h004, 32'h0, 1);
        access(1'b1, 10'h008, 32'hDEADBEEF, 0);
        access(1'b0, 10'h020, 32'h0, 2);
`ifdef CACHE_WB_STATS_EN
        @(posedge clk); #1;
        checks++;
        if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
            failures++;
            $display("FAIL stats_directed: got hits=%0d misses=%0d expected 2/2", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        access(1'b1, 10'h024, 32'hCAFEF00D, 0);
        access(1'b0, 10'h000, 32'h0, 0);
        access(1'b0, 10'h00C, 32'h0, 0);
        access(1'b1, 10'h3F3, 32'h0BADF00D, 0);
    endtask

    task automatic test_reset_alloc();
        int wt;
        test_reset();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000; cpu_wdata = '0;
        wt = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b0) && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        checks++;
        if (wt >= 20) begin
            failures++;
            $display("FAIL alloc_wait: got no allocate request expected one within 20 cycles");
        end
        rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = {4{32'hBAD0BAD0}};
        @(posedge clk); #1;
        mem_ready = 1'b0; rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_alloc: got mreq=%b ready=%b expected 0/0", mem_req, cpu_ready);
        end
        clearModel();
        access(1'b0, 10'h000, 32'h0, 1);
    endtask

    task automatic test_random();
        logic [9:0] a;
        for (int n = 0; n < 150; n++) begin
            a = 10'($urandom_range(0, 1023));
            a[9:5] = 5'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
        end
`ifdef CACHE_WB_STATS_EN
        @(posedge clk); #1;
        checks++;
        if (hit_count !== 16'(mHits) || miss_count !== 16'(mMisses)) begin
            failures++;
            $display("FAIL stats_random: got hits=%0d misses=%0d expected %0d/%0d",
                     hit_count, miss_count, mHits, mMisses);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) bMem[i] = $urandom;
        bMem[0] = 32'h11111111;
        bMem[1] = 32'h22222222;
        for (int i = 0; i < 256; i++) archMem[i] = bMem[i];
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_alloc();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
